// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
//   Bit-serial pattern transmitter feeding the detector block. On an accepted
//   start it captures a WIDTH-bit pattern and a frame count, then shifts the
//   pattern out MSB-first, one bit per clock, for the requested number of
//   frames. Consecutive frames are separated by GAP idle cycles.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   in_i        in   pattern, captured when start is accepted
//   repeat_i    in   frame count, captured when start is accepted (0 = reject)
//   start_i     in   level-sampled transmit request, honoured only in IDLE
//   sequence_o  out  registered serial data bit (0 when idle or in a gap)
//   valid_o     out  high while sequence_o carries a pattern bit
//   busy_o      out  high from the first bit through the last bit, gaps included
//   done_o      out  one-cycle pulse on the edge after the last bit

`timescale 1ns/1ps

module serial_pattern_tx #(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 4,
  parameter int GAP     = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_i,
  input  logic [COUNT_W-1:0] repeat_i,
  input  logic               start_i,
  output logic               sequence_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_e;

  state_e             state_q,    state_d;
  logic [WIDTH-1:0]   pattern_q,  pattern_d;
  logic [WIDTH-1:0]   shreg_q,    shreg_d;
  logic [BIT_W-1:0]   bitcnt_q,   bitcnt_d;
  logic [COUNT_W-1:0] frames_q,   frames_d;
  logic [GAP_W-1:0]   gapcnt_q,   gapcnt_d;
  logic               sequence_q, sequence_d;
  logic               valid_q,    valid_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pattern_q  <= '0;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      frames_q   <= '0;
      gapcnt_q   <= '0;
      sequence_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      frames_q   <= frames_d;
      gapcnt_q   <= gapcnt_d;
      sequence_q <= sequence_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic. The registered outputs are computed for the cycle that
  // follows the edge, so the first bit appears on the same edge that accepts
  // start. shreg holds the bits still to be sent after the one on the wire,
  // and bitcnt is the index of the bit currently on the wire.
  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    frames_d   = frames_q;
    gapcnt_d   = gapcnt_q;
    sequence_d = 1'b0;
    valid_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && (repeat_i != '0)) begin
          state_d    = S_SHIFT;
          pattern_d  = in_i;
          frames_d   = repeat_i;
          shreg_d    = in_i << 1;
          bitcnt_d   = '0;
          sequence_d = in_i[WIDTH-1];
          valid_d    = 1'b1;
          busy_d     = 1'b1;
        end
      end

      S_SHIFT: begin
        if (bitcnt_q != LAST_BIT) begin
          sequence_d = shreg_q[WIDTH-1];
          shreg_d    = shreg_q << 1;
          bitcnt_d   = bitcnt_q + 1'b1;
          valid_d    = 1'b1;
          busy_d     = 1'b1;
        end else begin
          // Last bit of a frame is on the wire; account for the frame.
          frames_d = frames_q - 1'b1;
          if (frames_q == COUNT_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (GAP > 0) begin
            state_d  = S_GAP;
            gapcnt_d = GAP_W'(1);
            busy_d   = 1'b1;
          end else begin
            // Back-to-back frames: restart from the captured pattern.
            sequence_d = pattern_q[WIDTH-1];
            shreg_d    = pattern_q << 1;
            bitcnt_d   = '0;
            valid_d    = 1'b1;
            busy_d     = 1'b1;
          end
        end
      end

      S_GAP: begin
        busy_d = 1'b1;
        // gapcnt counts gap cycles already shown on the wire.
        if (gapcnt_q == LAST_GAP) begin
          state_d    = S_SHIFT;
          sequence_d = pattern_q[WIDTH-1];
          shreg_d    = pattern_q << 1;
          bitcnt_d   = '0;
          valid_d    = 1'b1;
        end else begin
          gapcnt_d = gapcnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sequence_o = sequence_q;
  assign valid_o    = valid_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx
//   Directed bench for serial_pattern_tx. Two instances share all inputs:
//   one built with GAP=1 and one with GAP=0. Observed outputs are packed as
//   {sequence, valid, busy, done} and compared against hand-derived values.

`timescale 1ns/1ps

module tb_serial_pattern_tx;

  localparam logic [3:0] IDLE_OUT = 4'b0000;
  localparam logic [3:0] GAP_OUT  = 4'b0010;
  localparam logic [3:0] DONE_OUT = 4'b0001;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] patIn;
  logic [3:0] repIn;
  logic       start;

  logic seqGap,   validGap,   busyGap,   doneGap;
  logic seqNoGap, validNoGap, busyNoGap, doneNoGap;
  logic [3:0] obsGap, obsNoGap;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clock = ~clock;

  serial_pattern_tx #(.WIDTH(4), .COUNT_W(4), .GAP(1)) dutGap (
    .clock      (clock),
    .reset      (reset),
    .in_i       (patIn),
    .repeat_i   (repIn),
    .start_i    (start),
    .sequence_o (seqGap),
    .valid_o    (validGap),
    .busy_o     (busyGap),
    .done_o     (doneGap)
  );

  serial_pattern_tx #(.WIDTH(4), .COUNT_W(4), .GAP(0)) dutNoGap (
    .clock      (clock),
    .reset      (reset),
    .in_i       (patIn),
    .repeat_i   (repIn),
    .start_i    (start),
    .sequence_o (seqNoGap),
    .valid_o    (validNoGap),
    .busy_o     (busyNoGap),
    .done_o     (doneNoGap)
  );

  assign obsGap   = {seqGap, validGap, busyGap, doneGap};
  assign obsNoGap = {seqNoGap, validNoGap, busyNoGap, doneNoGap};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive inputs, then let one rising edge pass and settle just after it.
  task automatic applyStimulus(input logic st, input logic [3:0] pat,
                               input logic [3:0] rep);
    start = st;
    patIn = pat;
    repIn = rep;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] bitOut(input logic b);
    return {b, 3'b110};
  endfunction

  initial begin
    logic [3:0] pat;
    logic [3:0] pat2;
    logic [3:0] expGap;
    logic [3:0] expNoGap;

    // Reset held with an active request: nothing may come out.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'b1111, 4'd1);
      checkOutput($sformatf("reset[%0d]", i), obsGap, IDLE_OUT);
      checkOutput($sformatf("resetNoGap[%0d]", i), obsNoGap, IDLE_OUT);
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 4'b1111, 4'd1);
      checkOutput($sformatf("idleAfterReset[%0d]", i), obsGap, IDLE_OUT);
    end

    // Single frame 0010: bits at k..k+3, done at k+4.
    pat = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i == 0, pat, 4'd1);
      expGap = (i < 4) ? bitOut(pat[3-i]) : ((i == 4) ? DONE_OUT : IDLE_OUT);
      checkOutput($sformatf("single[%0d]", i), obsGap, expGap);
      checkOutput($sformatf("singleNoGap[%0d]", i), obsNoGap, expGap);
    end

    // Three frames of 1011: GAP=1 done at k+14, GAP=0 done at k+12.
    pat = 4'b1011;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(i == 0, pat, 4'd3);
      if (i < 14)
        expGap = ((i % 5) < 4) ? bitOut(pat[3-(i%5)]) : GAP_OUT;
      else
        expGap = (i == 14) ? DONE_OUT : IDLE_OUT;
      if (i < 12)
        expNoGap = bitOut(pat[3-(i%4)]);
      else
        expNoGap = (i == 12) ? DONE_OUT : IDLE_OUT;
      checkOutput($sformatf("repeat[%0d]", i), obsGap, expGap);
      checkOutput($sformatf("repeatNoGap[%0d]", i), obsNoGap, expNoGap);
    end

    // Input isolation: start held high and inputs changed while busy; the
    // request still high in the done cycle launches 0101 on the next edge.
    pat  = 4'b0010;
    pat2 = 4'b0101;
    for (int i = 0; i < 11; i++) begin
      if (i == 0)      applyStimulus(1'b1, pat,     4'd1);
      else if (i < 5)  applyStimulus(1'b1, pat2,    4'd7);
      else if (i == 5) applyStimulus(1'b1, pat2,    4'd1);
      else             applyStimulus(1'b0, 4'b1111, 4'd5);
      if (i < 4)       expGap = bitOut(pat[3-i]);
      else if (i == 4) expGap = DONE_OUT;
      else if (i < 9)  expGap = bitOut(pat2[3-(i-5)]);
      else if (i == 9) expGap = DONE_OUT;
      else             expGap = IDLE_OUT;
      checkOutput($sformatf("isolate[%0d]", i), obsGap, expGap);
    end

    // repeat=0 is rejected; a following valid request works.
    pat = 4'b1100;
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      applyStimulus(1'b1, 4'b1111, 4'd0);
      else if (i == 1) applyStimulus(1'b0, 4'b1111, 4'd0);
      else             applyStimulus(i == 2, pat, 4'd1);
      if (i < 2)       expGap = IDLE_OUT;
      else if (i < 6)  expGap = bitOut(pat[3-(i-2)]);
      else if (i == 6) expGap = DONE_OUT;
      else             expGap = IDLE_OUT;
      checkOutput($sformatf("zeroRepeat[%0d]", i), obsGap, expGap);
    end

    // Reset on the edge of the third bit: outputs clear, no done pulse.
    pat = 4'b1001;
    applyStimulus(1'b1, pat, 4'd2);
    checkOutput("midReset bit0", obsGap, bitOut(1'b1));
    applyStimulus(1'b0, pat, 4'd2);
    checkOutput("midReset bit1", obsGap, bitOut(1'b0));
    reset = 1'b1;
    applyStimulus(1'b1, pat, 4'd2);
    checkOutput("midReset clear", obsGap, IDLE_OUT);
    checkOutput("midResetNoGap clear", obsNoGap, IDLE_OUT);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, pat, 4'd2);
      checkOutput($sformatf("midReset quiet[%0d]", i), obsGap, IDLE_OUT);
      checkOutput($sformatf("midResetNoGap quiet[%0d]", i), obsNoGap, IDLE_OUT);
    end
    pat = 4'b0110;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i == 0, pat, 4'd1);
      expGap = (i < 4) ? bitOut(pat[3-i]) : ((i == 4) ? DONE_OUT : IDLE_OUT);
      checkOutput($sformatf("afterReset[%0d]", i), obsGap, expGap);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
